// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes understood by the 32-bit datapath ALU
// and the state encoding of the multiply sequencer that borrows it.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result bus and borrowed-ALU connection of the shift-add multiply sequencer.
interface alu_mul_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  // Handshake: start_i is a request sampled only while the sequencer is idle or
  // showing done; once accepted busy_o stays high for WIDTH cycles and start_i is
  // ignored; done_o then pulses for exactly one cycle with prod_o valid, and
  // prod_o holds that product until the next completion or reset.
  logic                 start_i;
  logic [WIDTH-1:0]     src1_i;
  logic [WIDTH-1:0]     src2_i;
  logic                 busy_o;
  logic                 done_o;
  logic [2*WIDTH-1:0]   prod_o;
  logic [WIDTH-1:0]     alu_src1_o;
  logic [WIDTH-1:0]     alu_src2_o;
  logic [3:0]           alu_ctrl_o;
  logic [WIDTH-1:0]     alu_result_i;
  alu_mul_state_e       state_o;

  modport master (
    output start_i, src1_i, src2_i, alu_result_i,
    input  busy_o, done_o, prod_o, alu_src1_o, alu_src2_o, alu_ctrl_o, state_o
  );

  modport slave (
    input  start_i, src1_i, src2_i, alu_result_i,
    output busy_o, done_o, prod_o, alu_src1_o, alu_src2_o, alu_ctrl_o, state_o
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned WIDTHxWIDTH -> 2*WIDTH shift-add multiplier that uses the external
// combinational ALU as its adder, one partial-product add per clock.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] ADD_CTRL = ALU_ADD
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_mul_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  alu_mul_state_e     state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] acc_nxt;

  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  assign sum    = bus.alu_result_i;

  // The ALU has no carry-out: a carry left the MSB if both operand MSBs were set,
  // or if exactly one was set and the sum MSB came out clear.
  assign carry = (acc_hi[WIDTH-1] & mcand_q[WIDTH-1]) |
                 ((acc_hi[WIDTH-1] | mcand_q[WIDTH-1]) & ~sum[WIDTH-1]);

  assign acc_nxt = acc_q[0] ? {carry, sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_hi, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            mcand_q <= bus.src1_i;
            acc_q   <= {{WIDTH{1'b0}}, bus.src2_i};
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            prod_q  <= acc_nxt;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.prod_o     = prod_q;
  assign bus.alu_src1_o = acc_hi;
  assign bus.alu_src2_o = mcand_q;
  assign bus.alu_ctrl_o = ADD_CTRL;
  assign bus.state_o    = state_q;

endmodule
